ahb_mem_bridge: RTL

- Parametrised, pipelined AHB-Lite slave that bridges AHB transfers to the banked memory controller port (MEM_BA/MEM_ADDR/W_EN/R_EN).
- Next generation of the single-cycle AHB front end: configurable width and geometry, HTRANS-qualified pipelined transfers, wait states driven by BUSYn, and a registered read return path.
- Sits between the AHB interconnect and the memory controller.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_mem_bridge_if.sv | 37 +++
 rtl/ahb_addr_decode.sv | 37 +++
 rtl/ahb_mem_bridge.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB transfer types, response codes and bridge FSM encoding for the AHB-to-memory bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_DONE = 3'd4,
    ST_ERR1    = 3'd5,
    ST_ERR2    = 3'd6
  } bridge_state_t;

  // Native HSIZE for a bus of the given width (log2 of the byte count).
  function automatic logic [2:0] hsize_for(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/ahb_mem_bridge_if.sv
// AHB-Lite slave bus plus memory-controller port of the bridge; slave = bridge side, master = bus/memory side.
interface ahb_mem_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BA_W   = 2,
  parameter int MA_W   = 12
);
  logic              HSEL;
  logic              HREADYIN;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              BUSYn;
  logic [DATA_W-1:0] HRDATA_R;

  logic              HREADYOUT;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;
  logic              ENABLE;
  logic [BA_W-1:0]   MEM_BA;
  logic [MA_W-1:0]   MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              W_EN;
  logic              R_EN;

  modport slave (
    input  HSEL, HREADYIN, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, BUSYn, HRDATA_R,
    output HREADYOUT, HRESP, HRDATA, ENABLE, MEM_BA, MEM_ADDR, MEM_WDATA, W_EN, R_EN
  );

  modport master (
    output HSEL, HREADYIN, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, BUSYn, HRDATA_R,
    input  HREADYOUT, HRESP, HRDATA, ENABLE, MEM_BA, MEM_ADDR, MEM_WDATA, W_EN, R_EN
  );
endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational HADDR split into bank/row address plus reject flag; zero latency, no backpressure.
// Reject flag (upper address bits set or non-native HSIZE) only exists when AHB_ERR_CHECK_EN is defined.
module ahb_addr_decode
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BA_W   = 2,
  parameter int MA_W   = 12
) (
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [2:0]        hsize_i,
  output logic [BA_W-1:0]   ba_o,
  output logic [MA_W-1:0]   ma_o,
  output logic              err_o
);

  assign ma_o = haddr_i[MA_W-1:0];
  assign ba_o = haddr_i[MA_W+BA_W-1:MA_W];

`ifdef AHB_ERR_CHECK_EN
  localparam logic [2:0] HSIZE_NATIVE = hsize_for(DATA_W);

  assign err_o = ((haddr_i >> (MA_W + BA_W)) != '0) || (hsize_i != HSIZE_NATIVE);
`else
  if (ADDR_W > MA_W + BA_W) begin : g_ignore_upper
    logic unused_upper;
    assign unused_upper = ^{hsize_i, haddr_i[ADDR_W-1:MA_W+BA_W]};
  end else begin : g_ignore_size
    logic unused_size;
    assign unused_size = ^hsize_i;
  end

  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/ahb_mem_bridge.sv
// Pipelined AHB-Lite slave to banked memory port: writes 0 wait + BUSYn stalls, reads 2 wait + BUSYn stalls.
// BUSYn=0 holds HREADYOUT low; AHB_ERR_CHECK_EN enables the two-cycle ERROR response for rejected transfers.
module ahb_mem_bridge
  import ahb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BA_W   = 2,
  parameter int MA_W   = 12
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_mem_bridge_if.slave bus
);

`ifdef AHB_ERR_CHECK_EN
  localparam logic ERR_RESP = HRESP_ERROR;
`else
  localparam logic ERR_RESP = HRESP_OKAY;
`endif

  bridge_state_t     state_q, state_d, accept_state;
  htrans_t           htrans;
  logic              accept;
  logic [BA_W-1:0]   dec_ba, ba_q, ba_d;
  logic [MA_W-1:0]   dec_ma, ma_q, ma_d;
  logic              dec_err;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              hreadyout, hresp, enable, w_en, r_en;

  ahb_addr_decode #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BA_W  (BA_W),
    .MA_W  (MA_W)
  ) u_decode (
    .haddr_i(bus.HADDR),
    .hsize_i(bus.HSIZE),
    .ba_o   (dec_ba),
    .ma_o   (dec_ma),
    .err_o  (dec_err)
  );

  assign htrans = htrans_t'(bus.HTRANS);
  assign accept = bus.HSEL && bus.HREADYIN && hreadyout &&
                  ((htrans == HT_NONSEQ) || (htrans == HT_SEQ));
  assign accept_state = dec_err ? ST_ERR1 : (bus.HWRITE ? ST_WR : ST_RD_REQ);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completing states chain straight into a transfer accepted on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = accept ? accept_state : ST_IDLE;
      ST_WR:      if (bus.BUSYn) state_d = accept ? accept_state : ST_IDLE;
      ST_RD_REQ:  if (bus.BUSYn) state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_RD_DONE;
      ST_RD_DONE: state_d = accept ? accept_state : ST_IDLE;
      ST_ERR1:    state_d = ST_ERR2;
      ST_ERR2:    state_d = accept ? accept_state : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    enable    = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    case (state_q)
      ST_WR: begin
        hreadyout = bus.BUSYn;
        w_en      = bus.BUSYn;
        enable    = 1'b1;
      end
      ST_RD_REQ: begin
        hreadyout = 1'b0;
        r_en      = bus.BUSYn;
        enable    = 1'b1;
      end
      ST_RD_WAIT: begin
        hreadyout = 1'b0;
        enable    = 1'b1;
      end
      ST_RD_DONE: begin
        enable    = 1'b1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = ERR_RESP;
      end
      ST_ERR2: begin
        hresp     = ERR_RESP;
      end
      default: begin
        hreadyout = 1'b1;
      end
    endcase
  end

  // Memory data arrives the cycle after R_EN, which is exactly the RD_WAIT cycle.
  always_comb begin
    ba_d     = accept ? dec_ba : ba_q;
    ma_d     = accept ? dec_ma : ma_q;
    hrdata_d = (state_q == ST_RD_WAIT) ? bus.HRDATA_R : hrdata_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ba_q     <= '0;
      ma_q     <= '0;
      hrdata_q <= '0;
    end else begin
      ba_q     <= ba_d;
      ma_q     <= ma_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
  assign bus.ENABLE    = enable;
  assign bus.MEM_BA    = ba_q;
  assign bus.MEM_ADDR  = ma_q;
  assign bus.MEM_WDATA = w_en ? bus.HWDATA : '0;
  assign bus.W_EN      = w_en;
  assign bus.R_EN      = r_en;

endmodule
